mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage LoongArch pipeline, between the execute stage and the write-back stage. It latches the execute-stage bus, aligns and sign/zero-extends load data returned by the synchronous data SRAM, and produces the write-back bus. It also drives forwarding/hazard information back to decode and a store-cancel indication to execute, and is flushed by write-back exceptions and `ertn`.

## Interface
- `EXCEPT_LEN`, 82, width of the exception/CSR field carried unchanged to write-back; bit 3 = syscall/exception, bit 2 = ertn, bit 1 = csr_re.
- `ES2MS_BUS_LEN`, 74+EXCEPT_LEN, bus layout MSB→LSB: pc[31:0], gr_we, dest[4:0], alu_result[31:0], res_from_mem, ld_op[2:0], except_zip.
- `MS2WS_BUS_LEN`, 70+EXCEPT_LEN, bus layout MSB→LSB: pc, gr_we, dest, final_result, except_zip.

- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `es2ms_valid` in 1: execute stage offers an instruction.
- `ms_allowin` out 1: this stage accepts an instruction this cycle.
- `es2ms_bus` in ES2MS_BUS_LEN: payload from execute.
- `data_sram_rdata` in 32: load data, valid during the cycle the load occupies this stage.
- `ws_allowin` in 1: write-back accepts.
- `ms2ws_valid` out 1: offer to write-back.
- `ms2ws_bus` out MS2WS_BUS_LEN: payload to write-back.
- `flush` in 1: wb_ex | ertn_flush from write-back.
- `ms_fwd_zip` out 39: {fwd_we, fwd_dest[4:0], fwd_data[31:0], fwd_csr_re}, used by decode for bypass and load/CSR-read stall.
- `ms_ex` out 1: the valid instruction here carries an exception or ertn; execute suppresses its store.

## Operation
- State: `ms_valid`, plus payload registers for every bus field.
- `ms_ready_go` = 1. `ms_allowin` = !ms_valid | (ms_ready_go & ws_allowin). `ms2ws_valid` = ms_valid & ms_ready_go.
- Valid update has the following priority:
  - reset → 0;
  - otherwise flush → 0;
  - otherwise, if ms_allowin, → es2ms_valid.
- Payload captured when es2ms_valid & ms_allowin, including while flush is high. This is harmless because valid is cleared.
- Load alignment uses sh = alu_result[1:0]. Byte = rdata >> (8·sh), low 8 bits; half = rdata >> (16·sh[1]), low 16 bits.
- ld_op encodings:
  - 000: word;
  - 001: byte, sign-extended;
  - 010: byte, zero-extended;
  - 011: half, sign-extended;
  - 100: half, zero-extended;
  - 101–111: treated as word.
- final_result = res_from_mem ? aligned load : alu_result.
- Forwarding:
  - fwd_we = ms_valid & gr_we & (dest != 0);
  - fwd_data = final_result;
  - fwd_csr_re = ms_valid & except_zip[1].
- ms_ex = ms_valid & (except_zip[3] | except_zip[2]).
- except_zip is passed through unmodified; write-back masks it with its own valid.

## Timing
- Reset values:
  - ms_valid = 0;
  - payload registers = 0;
  - hence ms2ws_valid = 0, fwd_we = 0, fwd_csr_re = 0, ms_ex = 0, ms_allowin = 1.
- Latency is one cycle: an instruction accepted at edge N is offered to write-back during cycle N to N+1.
- data_sram_rdata is combinationally consumed in the same cycle as ms_valid. It is not registered here.
- Stall: when ws_allowin = 0 and ms_valid = 1, payload and valid hold and ms_allowin = 0. The SRAM output is expected stable while stalled.
- Simultaneous flush and new input: the flush wins and the stage is empty next cycle.
- Reset mid-stall: the stage is empty next cycle regardless of the other inputs.
- Back-to-back: with ws_allowin = 1, one instruction per cycle with no bubbles.

## Test plan
- Reset then idle:
  - reset held 2 cycles;
  - required: ms2ws_valid = 0, ms_allowin = 1, ms_ex = 0, fwd_we = 0.
- Load byte signed:
  - alu_result = 0x1003, ld_op = 001, rdata = 0x80FF_1234;
  - required: final_result = 0xFFFF_FF80.
  - Same with ld_op = 010 → 0x0000_0080.
- Load half:
  - alu_result = 0x2002, ld_op = 011, rdata = 0x8001_7FFF;
  - required: 0xFFFF_8001.
  - ld_op = 100 → 0x0000_8001.
  - With alu_result = 0x2000 and ld_op = 011 → 0x0000_7FFF.
- Backpressure:
  - ws_allowin = 0 for 3 cycles with the stage holding pc = 0x1C00_0010;
  - required: ms_allowin = 0 and the bus stable.
  - On release, a new pc = 0x1C00_0014 is accepted the following edge.
- Flush:
  - stage holds a valid instruction, flush = 1 coincident with es2ms_valid = 1;
  - required: ms2ws_valid = 0 next cycle, and ms_ex = 0 after the flush.
- Exception and forwarding:
  - except_zip bit 3 set, gr_we = 1, dest = 5;
  - required: ms_ex = 1 and fwd_we = 1 with dest = 5.
  - dest = 0 → fwd_we = 0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: holds one instruction from execute, aligns/extends SRAM load
// data, and presents the write-back bus plus bypass and store-cancel information.
module mem_stage #(
  parameter int EXCEPT_LEN    = 82,
  parameter int ES2MS_BUS_LEN = 74 + EXCEPT_LEN,
  parameter int MS2WS_BUS_LEN = 70 + EXCEPT_LEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     es2ms_valid,
  output logic                     ms_allowin,
  input  logic [ES2MS_BUS_LEN-1:0] es2ms_bus,
  input  logic [31:0]              data_sram_rdata,
  input  logic                     ws_allowin,
  output logic                     ms2ws_valid,
  output logic [MS2WS_BUS_LEN-1:0] ms2ws_bus,
  input  logic                     flush,
  output logic [38:0]              ms_fwd_zip,
  output logic                     ms_ex
);

  logic                  ms_valid_q, ms_valid_d;
  logic [31:0]           pc_q, pc_d;
  logic                  gr_we_q, gr_we_d;
  logic [4:0]            dest_q, dest_d;
  logic [31:0]           alu_result_q, alu_result_d;
  logic                  res_from_mem_q, res_from_mem_d;
  logic [2:0]            ld_op_q, ld_op_d;
  logic [EXCEPT_LEN-1:0] except_zip_q, except_zip_d;

  logic [31:0]           in_pc;
  logic                  in_gr_we;
  logic [4:0]            in_dest;
  logic [31:0]           in_alu_result;
  logic                  in_res_from_mem;
  logic [2:0]            in_ld_op;
  logic [EXCEPT_LEN-1:0] in_except_zip;

  logic        ms_ready_go;
  logic [31:0] final_result;
  logic        fwd_we;
  logic        fwd_csr_re;

  function automatic logic [31:0] align_load(input logic [31:0] rdata,
                                             input logic [1:0]  sh,
                                             input logic [2:0]  op);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = signed'(rdata[{sh, 3'b000} +: 8]);
    h = signed'(rdata[{sh[1], 4'b0000} +: 16]);
    case (op)
      3'b001:  align_load = 32'(b);
      3'b010:  align_load = {24'd0, b};
      3'b011:  align_load = 32'(h);
      3'b100:  align_load = {16'd0, h};
      default: align_load = rdata;
    endcase
  endfunction

  assign {in_pc, in_gr_we, in_dest, in_alu_result,
          in_res_from_mem, in_ld_op, in_except_zip} = es2ms_bus;

  assign ms_ready_go = 1'b1;
  assign ms_allowin  = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign ms2ws_valid = ms_valid_q && ms_ready_go;

  always_comb begin
    ms_valid_d     = ms_valid_q;
    pc_d           = pc_q;
    gr_we_d        = gr_we_q;
    dest_d         = dest_q;
    alu_result_d   = alu_result_q;
    res_from_mem_d = res_from_mem_q;
    ld_op_d        = ld_op_q;
    except_zip_d   = except_zip_q;
    if (flush) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es2ms_valid;
    end
    // Payload may be captured during a flush; valid is already cleared so it is inert.
    if (es2ms_valid && ms_allowin) begin
      pc_d           = in_pc;
      gr_we_d        = in_gr_we;
      dest_d         = in_dest;
      alu_result_d   = in_alu_result;
      res_from_mem_d = in_res_from_mem;
      ld_op_d        = in_ld_op;
      except_zip_d   = in_except_zip;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q     <= 1'b0;
      pc_q           <= '0;
      gr_we_q        <= 1'b0;
      dest_q         <= '0;
      alu_result_q   <= '0;
      res_from_mem_q <= 1'b0;
      ld_op_q        <= '0;
      except_zip_q   <= '0;
    end else begin
      ms_valid_q     <= ms_valid_d;
      pc_q           <= pc_d;
      gr_we_q        <= gr_we_d;
      dest_q         <= dest_d;
      alu_result_q   <= alu_result_d;
      res_from_mem_q <= res_from_mem_d;
      ld_op_q        <= ld_op_d;
      except_zip_q   <= except_zip_d;
    end
  end

  // SRAM read data arrives in the cycle the load sits here and is consumed unregistered.
  assign final_result = res_from_mem_q ? align_load(data_sram_rdata, alu_result_q[1:0], ld_op_q)
                                       : alu_result_q;

  assign fwd_we     = ms_valid_q && gr_we_q && (dest_q != 5'd0);
  assign fwd_csr_re = ms_valid_q && except_zip_q[1];
  assign ms_fwd_zip = {fwd_we, dest_q, final_result, fwd_csr_re};
  assign ms_ex      = ms_valid_q && (except_zip_q[3] || except_zip_q[2]);
  assign ms2ws_bus  = {pc_q, gr_we_q, dest_q, final_result, except_zip_q};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: load-alignment vector table, hand sequences for stall/flush/
// reset/forwarding, and a randomized run against a transaction-level slot model.
module tb_mem_stage;
  localparam int EL = 82;
  localparam int EB = 74 + EL;
  localparam int WB = 70 + EL;

  logic          clk = 1'b0;
  logic          reset, es2ms_valid, ms_allowin, ws_allowin, ms2ws_valid, flush, ms_ex;
  logic [EB-1:0] es2ms_bus;
  logic [31:0]   data_sram_rdata;
  logic [WB-1:0] ms2ws_bus;
  logic [38:0]   ms_fwd_zip;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage #(.EXCEPT_LEN(EL), .ES2MS_BUS_LEN(EB), .MS2WS_BUS_LEN(WB)) dut (
    .clk(clk), .reset(reset), .es2ms_valid(es2ms_valid), .ms_allowin(ms_allowin),
    .es2ms_bus(es2ms_bus), .data_sram_rdata(data_sram_rdata), .ws_allowin(ws_allowin),
    .ms2ws_valid(ms2ws_valid), .ms2ws_bus(ms2ws_bus), .flush(flush),
    .ms_fwd_zip(ms_fwd_zip), .ms_ex(ms_ex)
  );

  wire [31:0] out_pc    = ms2ws_bus[WB-1 -: 32];
  wire [31:0] out_final = ms2ws_bus[EL+31:EL];
  wire        fwd_we    = ms_fwd_zip[38];
  wire [4:0]  fwd_dest  = ms_fwd_zip[37:33];
  wire [31:0] fwd_data  = ms_fwd_zip[32:1];
  wire        fwd_csr   = ms_fwd_zip[0];

  function automatic logic [EB-1:0] mk(input logic [31:0] pc, input logic we,
                                       input logic [4:0] dest, input logic [31:0] alu,
                                       input logic rfm, input logic [2:0] op,
                                       input logic [EL-1:0] ex);
    return {pc, we, dest, alu, rfm, op, ex};
  endfunction

  // Reference load result from the byte/halfword selection rules, using plain arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] addr,
                                           input logic [2:0] op);
    int unsigned b, h, a;
    a = addr % 4;
    b = (rd >> (8 * a)) % 256;
    h = (rd >> (16 * (a / 2))) % 65536;
    case (op)
      3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return h;
      default: return rd;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] alu;
    logic [2:0]  op;
    logic        rfm;
    logic [31:0] rd;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[11];

  // Randomized-run model: one slot holding the instruction currently in the stage.
  logic          m_valid;
  logic [31:0]   m_pc, m_alu;
  logic          m_we, m_rfm;
  logic [4:0]    m_dest;
  logic [2:0]    m_op;
  logic [EL-1:0] m_ex;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0]   rpc, ralu, fin;
    logic          rwe, rrfm, retire, room;
    logic [4:0]    rdest;
    logic [2:0]    rop;
    logic [EL-1:0] rex;

    vt[0]  = '{32'h0000_1003, 3'd1, 1'b1, 32'h80FF_1234, 32'hFFFF_FF80};
    vt[1]  = '{32'h0000_1003, 3'd2, 1'b1, 32'h80FF_1234, 32'h0000_0080};
    vt[2]  = '{32'h0000_2002, 3'd3, 1'b1, 32'h8001_7FFF, 32'hFFFF_8001};
    vt[3]  = '{32'h0000_2002, 3'd4, 1'b1, 32'h8001_7FFF, 32'h0000_8001};
    vt[4]  = '{32'h0000_2000, 3'd3, 1'b1, 32'h8001_7FFF, 32'h0000_7FFF};
    vt[5]  = '{32'h0000_2001, 3'd1, 1'b1, 32'h80FF_1234, 32'h0000_0012};
    vt[6]  = '{32'h0000_2002, 3'd1, 1'b1, 32'h80FF_1234, 32'hFFFF_FFFF};
    vt[7]  = '{32'h0000_2000, 3'd0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vt[8]  = '{32'h0000_2001, 3'd7, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vt[9]  = '{32'h1234_5678, 3'd1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678};
    vt[10] = '{32'h0000_2000, 3'd4, 1'b1, 32'h0000_F00D, 32'h0000_F00D};

    // Reset held two cycles while execute offers an instruction.
    reset = 1'b1; flush = 1'b0; ws_allowin = 1'b1; data_sram_rdata = '0;
    es2ms_valid = 1'b1;
    es2ms_bus = mk(32'hAAAA_5555, 1'b1, 5'd7, 32'h55, 1'b0, 3'd0, {EL{1'b1}});
    tick(); tick();
    chk("rst_valid", ms2ws_valid, 1'b0);
    chk("rst_allowin", ms_allowin, 1'b1);
    chk("rst_ex", ms_ex, 1'b0);
    chk("rst_fwd_we", fwd_we, 1'b0);
    chk("rst_csr", fwd_csr, 1'b0);
    chk("rst_bus", ms2ws_bus, '0);
    reset = 1'b0; es2ms_valid = 1'b0;
    tick();
    chk("idle_valid", ms2ws_valid, 1'b0);

    // Load alignment table.
    for (int i = 0; i < 11; i++) begin
      es2ms_valid = 1'b1;
      es2ms_bus = mk(32'h1C00_0000 + 32'(i * 4), 1'b1, 5'd3, vt[i].alu, vt[i].rfm, vt[i].op, '0);
      tick();
      es2ms_valid = 1'b0;
      data_sram_rdata = vt[i].rd;
      #1;
      chk($sformatf("vec%0d_final", i), out_final, vt[i].exp);
      chk($sformatf("vec%0d_valid", i), ms2ws_valid, 1'b1);
    end
    tick();

    // Backpressure: hold 0x1C000010 for three cycles while 0x1C000014 waits.
    es2ms_valid = 1'b1;
    es2ms_bus = mk(32'h1C00_0010, 1'b1, 5'd4, 32'h10, 1'b0, 3'd0, '0);
    tick();
    es2ms_bus = mk(32'h1C00_0014, 1'b1, 5'd4, 32'h14, 1'b0, 3'd0, '0);
    ws_allowin = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_allowin", ms_allowin, 1'b0);
      chk("bp_valid", ms2ws_valid, 1'b1);
      chk("bp_pc", out_pc, 32'h1C00_0010);
      tick();
    end
    ws_allowin = 1'b1;
    #1;
    chk("bp_release_allowin", ms_allowin, 1'b1);
    tick();
    chk("bp_next_pc", out_pc, 32'h1C00_0014);
    chk("bp_next_valid", ms2ws_valid, 1'b1);

    // Flush coincident with a new (excepting) instruction: flush wins.
    flush = 1'b1; es2ms_valid = 1'b1;
    es2ms_bus = mk(32'h1C00_0018, 1'b1, 5'd6, 32'h18, 1'b0, 3'd0, EL'(8));
    tick();
    flush = 1'b0; es2ms_valid = 1'b0;
    chk("flush_valid", ms2ws_valid, 1'b0);
    chk("flush_ex", ms_ex, 1'b0);
    chk("flush_fwd_we", fwd_we, 1'b0);
    chk("flush_payload_pc", out_pc, 32'h1C00_0018);

    // Exception / ertn / csr_re and forwarding.
    es2ms_valid = 1'b1;
    es2ms_bus = mk(32'h1C00_0020, 1'b1, 5'd5, 32'hCAFE_0001, 1'b0, 3'd0, EL'(8));
    tick();
    chk("exc_ms_ex", ms_ex, 1'b1);
    chk("exc_fwd_we", fwd_we, 1'b1);
    chk("exc_fwd_dest", fwd_dest, 5'd5);
    chk("exc_fwd_data", fwd_data, 32'hCAFE_0001);
    chk("exc_fwd_csr", fwd_csr, 1'b0);
    es2ms_bus = mk(32'h1C00_0024, 1'b1, 5'd0, 32'h24, 1'b0, 3'd0, EL'(4));
    tick();
    chk("dest0_fwd_we", fwd_we, 1'b0);
    chk("ertn_ms_ex", ms_ex, 1'b1);
    es2ms_bus = mk(32'h1C00_0028, 1'b1, 5'd9, 32'h28, 1'b0, 3'd0, EL'(2));
    tick();
    chk("csr_fwd_csr", fwd_csr, 1'b1);
    chk("csr_ms_ex", ms_ex, 1'b0);
    chk("csr_fwd_we", fwd_we, 1'b1);

    // Reset while stalled with a new offer pending.
    ws_allowin = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; es2ms_valid = 1'b0; ws_allowin = 1'b1;
    #1;
    chk("rststall_valid", ms2ws_valid, 1'b0);
    chk("rststall_allowin", ms_allowin, 1'b1);

    // Randomized run; the stage was just reset so the model slot starts empty and zeroed.
    m_valid = 1'b0; m_pc = '0; m_alu = '0; m_we = 1'b0; m_rfm = 1'b0;
    m_dest = '0; m_op = '0; m_ex = '0;
    for (int c = 0; c < 400; c++) begin
      es2ms_valid = ($urandom_range(0, 3) != 0);
      ws_allowin  = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      rpc   = $urandom;
      rwe   = 1'($urandom_range(0, 1));
      rdest = 5'($urandom_range(0, 31));
      ralu  = $urandom;
      rrfm  = 1'($urandom_range(0, 1));
      rop   = 3'($urandom_range(0, 7));
      rex   = EL'({$urandom, $urandom, $urandom});
      es2ms_bus = mk(rpc, rwe, rdest, ralu, rrfm, rop, rex);
      data_sram_rdata = $urandom;
      #1;
      fin = m_rfm ? ref_load(data_sram_rdata, m_alu, m_op) : m_alu;
      chk("rnd_allowin", ms_allowin, !m_valid || ws_allowin);
      chk("rnd_valid", ms2ws_valid, m_valid);
      chk("rnd_bus", ms2ws_bus, {m_pc, m_we, m_dest, fin, m_ex});
      chk("rnd_fwd", ms_fwd_zip, {m_valid && m_we && (m_dest != 0), m_dest, fin, m_valid && m_ex[1]});
      chk("rnd_ms_ex", ms_ex, m_valid && (m_ex[3] || m_ex[2]));
      @(posedge clk);
      retire = m_valid && ws_allowin;
      room   = !m_valid || retire;
      if (room && es2ms_valid) begin
        m_pc = rpc; m_we = rwe; m_dest = rdest; m_alu = ralu;
        m_rfm = rrfm; m_op = rop; m_ex = rex;
      end
      if (flush)     m_valid = 1'b0;
      else if (room) m_valid = es2ms_valid;
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
